// File: rtl/branch_predictor_bht_pkg.sv
// branch_predictor_bht_pkg: shared widths, counter codes, FSM states and table entry type
package branch_predictor_bht_pkg;
  localparam int XLEN = 32;
  localparam int BHT_ENTRIES = 64;
  localparam int TAG_BITS = 8;
  localparam int IDX_BITS = $clog2(BHT_ENTRIES);
  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT = 2'b10;
  localparam logic [1:0] CTR_ST = 2'b11;
  typedef enum logic {BHT_INIT, BHT_RUN} bht_state_e;
  typedef struct packed {
    logic valid;
    logic [TAG_BITS-1:0] tag;
    logic [XLEN-1:0] target;
    logic [1:0] ctr;
  } bht_entry_t;
  function automatic logic [IDX_BITS-1:0] pc_idx(input logic [XLEN-1:0] pc);
    return pc[IDX_BITS+1:2];
  endfunction
  function automatic logic [TAG_BITS-1:0] pc_tag(input logic [XLEN-1:0] pc);
    return pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
  endfunction
endpackage

// File: rtl/branch_predictor_bht_if.sv
// branch_predictor_bht_if: fetch lookup, EXU resolution and prediction signals; master drives fetch/EXU, slave is the predictor
interface branch_predictor_bht_if;
  import branch_predictor_bht_pkg::*;
  logic fetch_vld_in;
  logic [XLEN-1:0] fetch_pc_in;
  logic flush_in;
  logic exu_is_branch_in;
  logic exu_branch_taken_in;
  logic [XLEN-1:0] exu_branch_pc_in;
  logic [XLEN-1:0] exu_branch_target_in;
  logic pred_vld_out;
  logic pred_taken_out;
  logic [XLEN-1:0] pred_target_out;
  logic init_done_out;
  modport master (
    output fetch_vld_in, fetch_pc_in, flush_in,
    output exu_is_branch_in, exu_branch_taken_in, exu_branch_pc_in, exu_branch_target_in,
    input pred_vld_out, pred_taken_out, pred_target_out, init_done_out
  );
  modport slave (
    input fetch_vld_in, fetch_pc_in, flush_in,
    input exu_is_branch_in, exu_branch_taken_in, exu_branch_pc_in, exu_branch_target_in,
    output pred_vld_out, pred_taken_out, pred_target_out, init_done_out
  );
endinterface

// File: rtl/branch_predictor_bht_sat_ctr.sv
// bht_sat_ctr: 2-bit saturating counter next state; ctr_i/taken_i/alloc_i in, ctr_o out
module bht_sat_ctr
  import branch_predictor_bht_pkg::*;
(
  input  logic [1:0] ctr_i,
  input  logic       taken_i,
  input  logic       alloc_i,
  output logic [1:0] ctr_o
);
  always_comb begin
    ctr_o = alloc_i ? (taken_i ? CTR_WT : CTR_WNT) :
            taken_i ? (ctr_i == CTR_ST ? CTR_ST : ctr_i + 2'd1) :
                      (ctr_i == CTR_SNT ? CTR_SNT : ctr_i - 2'd1);
  end
endmodule

// File: rtl/branch_predictor_bht.sv
// branch_predictor_bht: tagged direct-mapped 2-bit BHT; clk/rst plus bus (slave) carrying lookup, training and prediction
module branch_predictor_bht
  import branch_predictor_bht_pkg::*;
(
  input logic clk,
  input logic rst,
  branch_predictor_bht_if.slave bus
);
  bht_state_e state_q, state_d;
  logic [IDX_BITS-1:0] ptr_q, ptr_d;
  bht_entry_t tbl_q [BHT_ENTRIES];
  bht_entry_t rd_e, up_e, wr_e;
  logic pred_vld_q, pred_taken_q;
  logic [XLEN-1:0] pred_target_q;
  logic lk, rd_hit, up_hit, wr_en;
  logic [IDX_BITS-1:0] wr_idx;
  logic [1:0] ctr_nxt;
  logic unused_pc;
  assign unused_pc = ^{bus.fetch_pc_in[XLEN-1:IDX_BITS+TAG_BITS+2], bus.fetch_pc_in[1:0],
                       bus.exu_branch_pc_in[XLEN-1:IDX_BITS+TAG_BITS+2], bus.exu_branch_pc_in[1:0]};
  always_comb begin
    state_d = (state_q == BHT_INIT && ptr_q == IDX_BITS'(BHT_ENTRIES - 1)) ? BHT_RUN : state_q;
    ptr_d = (state_q == BHT_INIT) ? ptr_q + 1'b1 : ptr_q;
  end
  // Lookups are forced to miss until the sweep finishes, since stale entries survive a reset.
  always_comb begin
    lk = bus.fetch_vld_in & ~bus.flush_in;
    rd_e = tbl_q[pc_idx(bus.fetch_pc_in)];
    rd_hit = state_q == BHT_RUN && rd_e.valid && rd_e.tag == pc_tag(bus.fetch_pc_in);
    up_e = tbl_q[pc_idx(bus.exu_branch_pc_in)];
    up_hit = up_e.valid && up_e.tag == pc_tag(bus.exu_branch_pc_in);
  end
  bht_sat_ctr u_ctr (
    .ctr_i(up_e.ctr),
    .taken_i(bus.exu_branch_taken_in),
    .alloc_i(~up_hit),
    .ctr_o(ctr_nxt)
  );
  // Single write port shared by the init sweep and training.
  always_comb begin
    wr_en = state_q == BHT_INIT || bus.exu_is_branch_in;
    wr_idx = (state_q == BHT_INIT) ? ptr_q : pc_idx(bus.exu_branch_pc_in);
    wr_e = (state_q == BHT_INIT) ? bht_entry_t'{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WNT} :
           bht_entry_t'{valid: 1'b1, tag: pc_tag(bus.exu_branch_pc_in),
                        target: (bus.exu_branch_taken_in || !up_hit) ? bus.exu_branch_target_in : up_e.target,
                        ctr: ctr_nxt};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BHT_INIT;
      ptr_q <= '0;
      pred_vld_q <= 1'b0;
      pred_taken_q <= 1'b0;
      pred_target_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      pred_vld_q <= lk;
      pred_taken_q <= lk & rd_hit & rd_e.ctr[1];
      pred_target_q <= (lk && rd_hit) ? rd_e.target : '0;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && wr_en) tbl_q[wr_idx] <= wr_e;
  end
  assign bus.pred_vld_out = pred_vld_q;
  assign bus.pred_taken_out = pred_taken_q;
  assign bus.pred_target_out = pred_target_q;
  assign bus.init_done_out = state_q == BHT_RUN;
endmodule

// File: tb/tb_branch_predictor_bht.sv
// tb_branch_predictor_bht: randomized and directed check of the BHT against a table model
module tb_branch_predictor_bht;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  branch_predictor_bht_if bus();
  branch_predictor_bht dut (.clk(clk), .rst(rst), .bus(bus));
  int n_chk = 0;
  int n_fail = 0;
  int run_cnt = 0;
  bit m_valid [64];
  int unsigned m_tag [64];
  int unsigned m_tgt [64];
  int m_ctr [64];
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask
  task automatic drive(bit fv, logic [31:0] fpc, bit fl, bit ub, bit ut, logic [31:0] upc, logic [31:0] utgt);
    bus.fetch_vld_in = fv;
    bus.fetch_pc_in = fpc;
    bus.flush_in = fl;
    bus.exu_is_branch_in = ub;
    bus.exu_branch_taken_in = ut;
    bus.exu_branch_pc_in = upc;
    bus.exu_branch_target_in = utgt;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_cnt = 0;
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 0;
      m_tag[i] = 0;
      m_tgt[i] = 0;
      m_ctr[i] = 1;
    end
    check("rst_vld", bus.pred_vld_out, 0);
    check("rst_taken", bus.pred_taken_out, 0);
    check("rst_target", bus.pred_target_out, 0);
    check("rst_init_done", bus.init_done_out, 0);
  endtask
  task automatic cyc(bit fv, logic [31:0] fpc, bit fl, bit ub, bit ut, logic [31:0] upc, logic [31:0] utgt);
    bit run;
    bit ev;
    bit hit;
    bit e_tk;
    int unsigned e_tg;
    int unsigned fi, ft, ui, utg;
    run = run_cnt >= 64;
    fi = (fpc >> 2) % 64;
    ft = (fpc >> 8) % 256;
    ui = (upc >> 2) % 64;
    utg = (upc >> 8) % 256;
    drive(fv, fpc, fl, ub, ut, upc, utgt);
    ev = fv && !fl;
    hit = run && m_valid[fi] && m_tag[fi] == ft;
    e_tk = ev && hit && m_ctr[fi] >= 2;
    e_tg = (ev && hit) ? m_tgt[fi] : 0;
    if (run && ub) begin
      if (!(m_valid[ui] && m_tag[ui] == utg)) begin
        m_valid[ui] = 1;
        m_tag[ui] = utg;
        m_tgt[ui] = utgt;
        m_ctr[ui] = ut ? 2 : 1;
      end else if (ut) begin
        m_ctr[ui] = (m_ctr[ui] == 3) ? 3 : m_ctr[ui] + 1;
        m_tgt[ui] = utgt;
      end else begin
        m_ctr[ui] = (m_ctr[ui] == 0) ? 0 : m_ctr[ui] - 1;
      end
    end
    run_cnt++;
    @(posedge clk);
    #1;
    check("pred_vld", bus.pred_vld_out, ev);
    check("pred_taken", bus.pred_taken_out, e_tk);
    check("pred_target", bus.pred_target_out, e_tg);
    check("init_done", bus.init_done_out, run_cnt >= 64);
  endtask
  function automatic logic [31:0] rpc();
    return ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3) | ($urandom_range(0, 1) << 20);
  endfunction
  task automatic rand_cycles(int n);
    for (int i = 0; i < n; i++)
      cyc($urandom_range(0, 3) != 0, rpc(), $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
          $urandom_range(0, 1) == 1, rpc(), $urandom);
  endtask
  initial begin
    do_reset();
    repeat (30) cyc(1, 32'h1000, 0, 1, 1, 32'h1000, 32'h0800);
    do_reset();
    for (int i = 0; i < 64; i++) cyc(1, 32'h3000, 0, 1, 1, 32'h3000, 32'h1234);
    cyc(1, 32'h3000, 0, 0, 0, 0, 0);
    cyc(1, 32'h1000, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 32'h1000, 32'h0800);
    cyc(1, 32'h1000, 0, 0, 0, 0, 0);
    repeat (2) cyc(0, 0, 0, 1, 0, 32'h1000, 32'h0);
    cyc(1, 32'h1000, 0, 0, 0, 0, 0);
    repeat (4) cyc(1, 32'h1000, 0, 1, 1, 32'h1000, 32'h0900);
    cyc(1, 32'h1000, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 32'h1000, 32'h0800);
    cyc(0, 0, 0, 1, 0, 32'h1100, 32'h0700);
    cyc(1, 32'h1000, 0, 0, 0, 0, 0);
    cyc(1, 32'h1100, 0, 0, 0, 0, 0);
    repeat (2) cyc(0, 0, 0, 1, 1, 32'h2000, 32'h4000);
    cyc(1, 32'h2000, 0, 1, 0, 32'h2000, 32'h0);
    cyc(1, 32'h2000, 0, 0, 0, 0, 0);
    cyc(1, 32'h2000, 1, 0, 0, 0, 0);
    cyc(1, 32'h2000, 0, 0, 0, 0, 0);
    rand_cycles(400);
    do_reset();
    rand_cycles(300);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
